// File: rtl/iir_ar_mac_if.sv
// iir_ar_mac_if: sample, coefficient-RAM and result bundle for iir_ar_mac.
// slave = the filter; master = the sample source / coefficient RAM side.
interface iir_ar_mac_if #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3
);
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] x_in;
  logic                         hist_clr;
  logic [ADDR_WIDTH-1:0]        coef_addr;
  logic signed [DATA_WIDTH-1:0] coef_data;
  logic signed [DATA_WIDTH-1:0] y_out;
  logic                         y_valid;
  logic                         busy;

  modport master (
    output in_valid, x_in, hist_clr, coef_data,
    input  in_ready, coef_addr, y_out, y_valid, busy
  );

  modport slave (
    input  in_valid, x_in, hist_clr, coef_data,
    output in_ready, coef_addr, y_out, y_valid, busy
  );
endinterface

// File: rtl/iir_ar_mac.sv
// iir_ar_mac: serial all-pole IIR, y[n] = x[n] + sum a_k*y[n-k], one MAC/cycle.
// Ports: CLK, RST (async active-low), bus (iir_ar_mac_if.slave: sample
// handshake, coef RAM addr/data, y_out/y_valid, busy, hist_clr).
// Macro IIR_AR_MAC_SAT_EN: saturate output; undefined: wrap to DATA_WIDTH.
module iir_ar_mac #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3,
  parameter int ORDER      = 7,
  parameter int COEF_FRAC  = 4
) (
  input logic          CLK,
  input logic          RST,
  iir_ar_mac_if.slave  bus
);
  localparam int DW    = DATA_WIDTH;
  localparam int ACC_W = 2 * DW + $clog2(ORDER + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] K_LAST =
    ADDR_WIDTH'(ORDER - 1);

  logic [1:0]              state_q, state_d;
  logic [ADDR_WIDTH-1:0]   k_q, k_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [DW-1:0]    hist_q [ORDER];
  logic signed [DW-1:0]    hist_d [ORDER];
  logic signed [DW-1:0]    y_q, y_d;
  logic                    yv_q, yv_d;
  logic                    rdy_q;

  logic                    is_idle, is_mac, is_out;
  logic                    accept;
  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] acc_nx;
  logic signed [DW-1:0]    y_red;

  assign is_idle = (state_q == S_IDLE);
  assign is_mac  = (state_q == S_MAC);
  assign is_out  = (state_q == S_OUT);

  // rdy_q keeps in_ready low until the first edge after reset release
  assign bus.in_ready  = rdy_q && is_idle;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.busy      = !is_idle;
  assign bus.coef_addr = is_mac ? k_q : '0;
  assign bus.y_out     = y_q;
  assign bus.y_valid   = yv_q;

  assign prod   = $signed(bus.coef_data) * hist_q[k_q];
  assign acc_nx = acc_q + ACC_W'(prod);

`ifdef IIR_AR_MAC_SAT_EN
  localparam logic signed [ACC_W-1:0] Y_MAX =
    {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN =
    {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [ACC_W-1:0] shr;
  assign shr = acc_nx >>> COEF_FRAC;

  always_comb begin
    y_red = shr[DW-1:0];
    if (shr > Y_MAX) y_red = Y_MAX[DW-1:0];
    if (shr < Y_MIN) y_red = Y_MIN[DW-1:0];
  end
`else
  // low bits of the floor shift are simply a slice of the accumulator
  assign y_red = acc_nx[COEF_FRAC +: DW];
`endif

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    hist_d  = hist_q;
    y_d     = y_q;
    yv_d    = 1'b0;
    unique case (1'b1)
      is_idle: begin
        if (bus.hist_clr) begin
          for (int i = 0; i < ORDER; i++) hist_d[i] = '0;
        end
        if (accept) begin
          acc_d   = ACC_W'($signed(bus.x_in)) <<< COEF_FRAC;
          k_d     = '0;
          state_d = S_MAC;
        end
      end
      is_mac: begin
        acc_d = acc_nx;
        k_d   = k_q + 1'b1;
        // result is registered on the last tap so y_valid lands in OUT
        if (k_q == K_LAST) begin
          k_d     = '0;
          y_d     = y_red;
          yv_d    = 1'b1;
          state_d = S_OUT;
        end
      end
      is_out: begin
        hist_d[0] = y_q;
        for (int i = 1; i < ORDER; i++) hist_d[i] = hist_q[i-1];
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      yv_q    <= 1'b0;
      rdy_q   <= 1'b0;
      for (int i = 0; i < ORDER; i++) hist_q[i] <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      yv_q    <= yv_d;
      rdy_q   <= 1'b1;
      for (int i = 0; i < ORDER; i++) hist_q[i] <= hist_d[i];
    end
  end
endmodule

// File: tb/tb_iir_ar_mac.sv
// tb_iir_ar_mac: directed vector table plus streaming/reset/clear sequences.
// DATA_WIDTH=6, ADDR_WIDTH=3, ORDER=7, COEF_FRAC=4.
module tb_iir_ar_mac;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  logic signed [5:0] coef_mem [8];

  iir_ar_mac_if #(.DATA_WIDTH(6), .ADDR_WIDTH(3)) bus ();

  assign bus.coef_data = coef_mem[bus.coef_addr];

  iir_ar_mac #(
    .DATA_WIDTH(6),
    .ADDR_WIDTH(3),
    .ORDER(7),
    .COEF_FRAC(4)
  ) dut (
    .CLK(clk),
    .RST(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int a1;
    int a2;
    bit clr;
    int x;
    int y;
  } vec_t;

  vec_t vt [14];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_coefs(input int a1, input int a2);
    for (int i = 0; i < 8; i++) coef_mem[i] = '0;
    coef_mem[0] = 6'(a1);
    coef_mem[1] = 6'(a2);
  endtask

  // called at a negedge; returns at the negedge of the y_valid cycle
  task automatic send(input int x, input bit clr,
                      output int y, output int lat, output int bz);
    int n;
    lat = -1;
    bz  = 0;
    y   = 0;
    n   = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b1;
    bus.x_in     = 6'(x);
    bus.hist_clr = clr;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.hist_clr = 1'b0;
    bus.x_in     = '0;
    for (int i = 1; i <= 20; i++) begin
      if (bus.busy) bz++;
      if (bus.y_valid) begin
        lat = i;
        y   = int'(bus.y_out);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    int y, lat, bz, exp_ovf;
    tests = 0;
    fails = 0;
`ifdef IIR_AR_MAC_SAT_EN
    exp_ovf = 31;
`else
    exp_ovf = -4;
`endif
    vt[0]  = '{0, 0, 1, 5, 5};
    vt[1]  = '{8, 0, 1, 16, 16};
    vt[2]  = '{8, 0, 0, 0, 8};
    vt[3]  = '{8, 0, 0, 0, 4};
    vt[4]  = '{8, 0, 0, 0, 2};
    vt[5]  = '{8, 0, 0, -3, -2};
    vt[6]  = '{31, 0, 1, 31, 31};
    vt[7]  = '{31, 0, 0, 0, exp_ovf};
    vt[8]  = '{8, 0, 1, -3, -3};
    vt[9]  = '{8, 0, 0, 0, -2};
    vt[10] = '{-16, 0, 1, 10, 10};
    vt[11] = '{-16, 0, 0, 0, -10};
    vt[12] = '{8, 8, 1, 16, 16};
    vt[13] = '{8, 8, 0, 0, 8};

    bus.in_valid = 1'b0;
    bus.x_in     = '0;
    bus.hist_clr = 1'b0;
    set_coefs(0, 0);
    rst_n = 1'b0;
    #12;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_ready", int'(bus.in_ready), 0);
    chk("rst_yvalid", int'(bus.y_valid), 0);
    chk("rst_yout", int'(bus.y_out), 0);
    chk("rst_addr", int'(bus.coef_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", int'(bus.in_ready), 1);

    for (int v = 0; v < 14; v++) begin
      set_coefs(vt[v].a1, vt[v].a2);
      send(vt[v].x, vt[v].clr, y, lat, bz);
      chk($sformatf("vec%0d_y", v), y, vt[v].y);
      chk($sformatf("vec%0d_lat", v), lat, 8);
      if (v == 0) chk("vec0_busy", bz, 8);
    end
    // two-tap follow-on: (8*8 + 8*16)/16
    send(0, 0, y, lat, bz);
    chk("two_tap_y", y, 12);

    // in_valid held high with a changing sample every cycle
    set_coefs(0, 0);
    bus.in_valid = 1'b1;
    for (int c = 0; c < 27; c++) begin
      int p;
      p = c % 9;
      bus.x_in = 6'(c + 1);
      chk($sformatf("strm_rdy%0d", c), int'(bus.in_ready), int'(p == 0));
      chk($sformatf("strm_addr%0d", c), int'(bus.coef_addr),
          (p >= 1 && p <= 7) ? p - 1 : 0);
      chk($sformatf("strm_yv%0d", c), int'(bus.y_valid), int'(p == 8));
      if (p == 8) chk($sformatf("strm_y%0d", c), int'(bus.y_out), c - 7);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.x_in     = '0;
    @(negedge clk);

    // reset in the third MAC cycle with non-zero history
    set_coefs(8, 0);
    send(16, 1, y, lat, bz);
    chk("pre_rst_y", y, 16);
    bus.in_valid = 1'b1;
    bus.x_in     = 6'd7;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mac3_addr", int'(bus.coef_addr), 2);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_addr", int'(bus.coef_addr), 0);
    chk("abort_ready", int'(bus.in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (bus.y_valid) seen++;
      end
      chk("abort_no_yvalid", seen, 0);
    end
    send(5, 0, y, lat, bz);
    chk("post_rst_y", y, 5);

    // standalone history clear in IDLE
    send(16, 1, y, lat, bz);
    chk("pre_clr_y", y, 16);
    bus.hist_clr = 1'b1;
    @(negedge clk);
    bus.hist_clr = 1'b0;
    send(0, 0, y, lat, bz);
    chk("post_clr_y", y, 0);
    chk("hold_y", int'(bus.y_out), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/iir_ar_mac.md
IIR_AR_MAC -- requirements
Module: iir_ar_mac

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 6: sample/coefficient width, signed two's complement.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3: coefficient RAM address width.
REQ-003 SHALL have parameter ORDER, default 7: feedback taps a1..aORDER; ORDER <= 2**ADDR_WIDTH.
REQ-004 SHALL have parameter COEF_FRAC, default 4: fractional bits of coefficients.
REQ-005 CLK  input  1  clock; all state updates on rising edge.
REQ-006 RST  input  1  reset, asynchronous, active-low.
REQ-007 in_valid  input  1  x_in valid.
REQ-008 in_ready  output  1  block can accept a sample this cycle.
REQ-009 x_in  input  DATA_WIDTH  signed input sample x[n].
REQ-010 hist_clr  input  1  synchronous clear of output history (honoured only in IDLE).
REQ-011 coef_addr  output  ADDR_WIDTH  address into coefficient RAM; coefficient a(k+1) stored at address k.
REQ-012 coef_data  input  DATA_WIDTH  signed RAM read data, valid combinationally in the same cycle as coef_addr.
REQ-013 y_out  output  DATA_WIDTH  signed output y[n].
REQ-014 y_valid  output  1  one-cycle pulse, y_out valid.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 SHALL compute y[n] = x[n] + sum(k=1..ORDER) a_k*y[n-k], coefficients scaled by 2**-COEF_FRAC.
REQ-017 SHALL implement FSM states IDLE, MAC, OUT; IDLE->MAC on in_valid&&in_ready; MAC->OUT after ORDER MAC cycles; OUT->IDLE unconditionally.
REQ-018 in_ready SHALL be 1 only in IDLE; x_in ignored in all other states, in_valid may stay high without effect.
REQ-019 On accept, acc SHALL load x_in sign-extended and shifted left COEF_FRAC; tap counter k SHALL load 0.
REQ-020 In MAC, coef_addr SHALL equal k and acc SHALL add coef_data*hist[k] (full-precision signed product); hist[0]=y[n-1].
REQ-021 Accumulator width SHALL be 2*DATA_WIDTH+clog2(ORDER+1) to avoid internal overflow.
REQ-022 In OUT, y_out SHALL register acc arithmetic-shifted right COEF_FRAC (floor), reduced per REQ-030; y_valid SHALL pulse 1; hist SHALL shift (hist[0]<=new y, oldest discarded).
REQ-023 y_out SHALL hold its value until the next OUT cycle.
REQ-024 Latency: accept in cycle 0, y_valid in cycle ORDER+1; throughput one sample per ORDER+2 cycles.
REQ-025 coef_addr SHALL be 0 outside MAC.
REQ-026 hist_clr in IDLE SHALL zero all hist entries next cycle; if coincident with accept, clear takes effect first (sample uses zero history).

Reset
REQ-027 RST low SHALL immediately force state IDLE, k=0, acc=0, all hist=0, y_out=0, y_valid=0, coef_addr=0, busy=0; in_ready=1 from the first edge after RST high.
REQ-028 Reset during MAC or OUT SHALL abort the sample with no y_valid pulse.

Configuration
REQ-029 Macro IIR_AR_MAC_SAT_EN SHALL select output reduction mode.
REQ-030 Defined: shifted acc saturates to [-2**(DATA_WIDTH-1), 2**(DATA_WIDTH-1)-1]; undefined: low DATA_WIDTH bits kept (wrap). History always stores the reduced y_out.

Verification (DATA_WIDTH=6, ORDER=7, COEF_FRAC=4)
REQ-031 All coefs 0, x_in=5 -> y_out=5, y_valid exactly 8 cycles after accept, busy high 8 cycles.
REQ-032 a1=8 (0.5), others 0, inputs 16,0,0,0 -> y_out 16,8,4,2.
REQ-033 a1=31, others 0, inputs 31,0 -> y_out 31 then 31 with IIR_AR_MAC_SAT_EN, 31 then -4 without.
REQ-034 in_valid held high with x_in changing -> only samples present in IDLE cycles accepted, one per 9 cycles; coef_addr steps 0..6 in each MAC phase.
REQ-035 RST low in 3rd MAC cycle -> no y_valid, hist zero; next x_in=5 with coefs a1=8 -> y_out=5.
REQ-036 After y=16 with a1=8, hist_clr pulse in IDLE then x_in=0 -> y_out=0.
